tex_table_writer: RTL and testbench
===================================

// Module: tex_table_writer
// PURPOSE
//  Writer side of the transform character table. Accepts a stream of {lhs,rhs} ASCII pairs, line by line.
//  Writes each pair into the 16-bit character memory and packs consecutive pairs for each line.
//  At the end of each line, writes a {len[5:0], start[5:0]} line pointer into the pointer table.
//  The transformer later reads the same memories.
//  Sits between the host/load interface and the two table RAMs.
// PARAMETERS
//  CHAR_DEPTH  64  char-memory entries reachable by the 6-bit pointer start field (addresses 0..63)
//  MAX_LINES   64  pointer-table entries (line index 0..63)
// PORTS
//  clk          in   1   system clock, single domain
//  rst_n        in   1   asynchronous, active-low reset
//  tbl_clr      in   1   synchronous clear of write pointers/status (1-cycle pulse)
//  in_valid     in   1   pair beat valid
//  in_ready     out  1   block can accept beat
//  in_lhs       in   8   input-side ASCII char
//  in_rhs       in   8   transformed ASCII char
//  in_last      in   1   beat is final pair of current line
//  mem_we       out  1   char-memory write strobe
//  mem_addr     out  8   char-memory address (upper 2 bits always 0)
//  mem_din      out  16  {lhs,rhs}
//  ptr_we       out  1   pointer-table write strobe
//  ptr_line     out  6   line index written
//  ptr_data     out  12  {len[11:6], start[5:0]}
//  line_count   out  7   lines committed since reset/clear (0..64)
//  full         out  1   no further beats accepted
//  err          out  1   sticky overflow error
// BEHAVIOUR
//  Reset (rst_n low, async): every output is 0. Internal wr_ptr=0, line_start=0, line_len=0, line_idx=0, state=ACCEPT.
//  A beat transfers on in_valid & in_ready.
//  in_ready = (state==ACCEPT) & ~full & ~err.
//  in_ready does not depend on in_valid.
//  State ACCEPT, on transfer:
//   - The pair is written in the same cycle: mem_we=1 combinationally from the transfer, mem_addr=wr_ptr, mem_din={in_lhs,in_rhs}.
//   - wr_ptr++ and line_len++.
//   - If in_last=1, go to COMMIT.
//  State COMMIT (1 cycle, in_ready=0):
//   - ptr_we=1, ptr_line=line_idx, ptr_data={line_len,line_start}.
//   - Then line_idx++, line_count++, line_start=wr_ptr, line_len=0, return to ACCEPT.
//  Latency: last beat to ptr_we is exactly 1 cycle.
//  Line lengths:
//   - An empty line (in_last on the first beat) has len=1.
//   - A zero-length line cannot be written.
//  full is set after a COMMIT when either:
//   - line_idx reaches MAX_LINES (line_count=64), or
//   - wr_ptr reaches CHAR_DEPTH.
//  Overflow: a transfer is accepted when wr_ptr==CHAR_DEPTH-1 and in_last=0.
//   - That beat is still written.
//   - err is set and the state goes to HALT.
//   - No pointer is written for the partial line; in_ready=0 in HALT.
//  tbl_clr:
//   - Returns all state to reset values except that the memories are untouched.
//   - Wins over a simultaneous beat: no write, beat not accepted.
//   - Clears err and full.
//  Reset mid-line: the partial line is discarded and no ptr write occurs.
//  No arithmetic wraps silently: line_len is capped by the overflow rule (max 63 reachable per line).
// CONFIGURATION
//  TEX_WR_BLANK_SKIP_EN defined:
//   - A transferred beat with {in_lhs,in_rhs}==16'h2020 and in_last=0 is consumed without mem_we and without incrementing wr_ptr or line_len.
//   - With in_last=1, it still commits if line_len>0; otherwise it is dropped entirely.
//  Undefined: blank pairs are stored like any other pair.
// STRUCTURE
//  Shared package tex_pkg:
//   - BLANK_PAIR=16'h2020
//   - PTR_LEN_MSB/LSB=11/6, PTR_START_MSB/LSB=5/0
//   - state encoding ACCEPT/COMMIT/HALT
//  Single flat module; no sub-module (the pointer packer is too small to split).
// TESTING
//  1 Reset, then one 2-beat line ('1','1'),('s','s',last) -> mem_we at addr 0,1; next cycle ptr_we line 0, ptr_data=12'h080 (len2,start0).
//  2 Two lines of 3 and 2 beats -> ptr line0={3,0}=12'h0C0, line1={2,3}=12'h083; line_count=2.
//  3 Hold in_valid through last beat -> in_ready low exactly one cycle (COMMIT), no beat lost or duplicated.
//  4 65 beats with no in_last -> addr 0..63 written, err=1 after beat 64, no ptr_we, in_ready=0; tbl_clr -> err=0, in_ready=1.
//  5 rst_n low during beat 2 of a line -> all outputs 0 immediately; next line lands at start 0, line 0.
//  6 (TEX_WR_BLANK_SKIP_EN) beats 'a',16'h2020,'b'(last) -> 2 writes at addr 0,1, ptr {2,0}; without the macro, 3 writes and ptr {3,0}.

Source files
------------

// File: rtl/tex_pkg.sv
// Purpose : shared constants and types for the transform character table
//           (writer side and the transformer that reads the same memories).
// Contents: table geometry, pointer-entry field positions, blank-pair code,
//           writer state encoding and a pointer-entry packing helper.
package tex_pkg;

  localparam int unsigned CHAR_DEPTH    = 64;  // char-memory entries reachable by start field
  localparam int unsigned MAX_LINES     = 64;  // pointer-table entries
  localparam int unsigned FIELD_W       = 6;   // width of len and start fields
  localparam int unsigned WR_PTR_W      = 7;   // holds 0..CHAR_DEPTH
  localparam int unsigned LINE_CNT_W    = 7;   // holds 0..MAX_LINES
  localparam int unsigned MEM_ADDR_W    = 8;
  localparam int unsigned MEM_DATA_W    = 16;
  localparam int unsigned PTR_DATA_W    = 12;

  localparam int unsigned PTR_LEN_MSB   = 11;
  localparam int unsigned PTR_LEN_LSB   = 6;
  localparam int unsigned PTR_START_MSB = 5;
  localparam int unsigned PTR_START_LSB = 0;

  localparam logic [MEM_DATA_W-1:0] BLANK_PAIR = 16'h2020;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HALT   = 2'd2
  } wr_state_e;

  // Build a pointer-table entry {len, start}.
  function automatic logic [PTR_DATA_W-1:0] pack_ptr(input logic [FIELD_W-1:0] len,
                                                     input logic [FIELD_W-1:0] start);
    logic [PTR_DATA_W-1:0] v;
    v = '0;
    v[PTR_LEN_MSB:PTR_LEN_LSB]     = len;
    v[PTR_START_MSB:PTR_START_LSB] = start;
    return v;
  endfunction

endpackage

// File: rtl/tex_table_writer_if.sv
// Purpose : pair-beat stream from the host/load side into the table writer.
// Signals : in_valid  beat valid (master -> slave)
//           in_ready  writer can accept a beat (slave -> master)
//           in_lhs    input-side ASCII char
//           in_rhs    transformed ASCII char
//           in_last   beat is the final pair of the current line
interface tex_table_writer_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_lhs;
  logic [7:0] in_rhs;
  logic       in_last;

  modport master (output in_valid, in_lhs, in_rhs, in_last, input in_ready);
  modport slave  (input in_valid, in_lhs, in_rhs, in_last, output in_ready);

endinterface

// File: rtl/tex_table_writer.sv
// Purpose : writer side of the transform character table. Stores each {lhs,rhs}
//           pair into the 16-bit char memory and, at the end of every line,
//           writes a {len,start} pointer entry into the pointer table.
// Ports   : clk, rst_n          clock, async active-low reset
//           tbl_clr             sync clear of write pointers and status
//           s_in                pair-beat stream (tex_table_writer_if.slave)
//           mem_we/addr/din     char-memory write port (same cycle as the beat)
//           ptr_we/line/data    pointer-table write port (cycle after last beat)
//           line_count          lines committed since reset/clear
//           full, err           no more beats accepted / sticky overflow
// Config  : TEX_WR_BLANK_SKIP_EN - when defined, blank pairs (16'h2020) are
//           consumed without being stored; undefined, they are stored normally.
module tex_table_writer
  import tex_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tbl_clr,
  tex_table_writer_if.slave      s_in,
  output logic                   mem_we,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [MEM_DATA_W-1:0]  mem_din,
  output logic                   ptr_we,
  output logic [FIELD_W-1:0]     ptr_line,
  output logic [PTR_DATA_W-1:0]  ptr_data,
  output logic [LINE_CNT_W-1:0]  line_count,
  output logic                   full,
  output logic                   err
);

  wr_state_e              r_state;
  logic [WR_PTR_W-1:0]    r_wr_ptr;
  logic [FIELD_W-1:0]     r_line_start;
  logic [FIELD_W-1:0]     r_line_len;
  logic [LINE_CNT_W-1:0]  r_line_count;
  logic                   r_full;
  logic                   r_err;
  logic                   r_ptr_we;
  logic [FIELD_W-1:0]     r_ptr_line;
  logic [PTR_DATA_W-1:0]  r_ptr_data;

  logic                   w_ready;
  logic                   w_xfer;
  logic [MEM_DATA_W-1:0]  w_pair;
  logic                   w_blank;
  logic                   w_store;
  logic [FIELD_W-1:0]     w_len_nxt;
  logic                   w_commit;
  logic                   w_ovf;

  // Ready is held low while in reset and while a clear is pending so a beat
  // offered in either case is never seen as transferred.
  assign w_ready = rst_n & ~tbl_clr & (r_state == ST_ACCEPT) & ~r_full & ~r_err;
  assign w_xfer  = s_in.in_valid & w_ready;
  assign w_pair  = {s_in.in_lhs, s_in.in_rhs};

`ifdef TEX_WR_BLANK_SKIP_EN
  assign w_blank = (w_pair == BLANK_PAIR);
`else
  assign w_blank = 1'b0;
`endif

  // Beat that actually occupies a char-memory entry.
  assign w_store   = w_xfer & ~w_blank;
  assign w_len_nxt = r_line_len + FIELD_W'(w_store);

  // A last beat commits unless it is a skipped blank closing an empty line.
  assign w_commit  = w_xfer & s_in.in_last & (w_store | (r_line_len != '0));

  // Storing into the final entry overflows unless it closes the line; a
  // 64-pair line would not fit the 6-bit len field, so it overflows too.
  assign w_ovf = w_store & (r_wr_ptr == WR_PTR_W'(CHAR_DEPTH - 1)) &
                 (~s_in.in_last | (r_line_len == FIELD_W'(CHAR_DEPTH - 1)));

  // Writer state, pointers and registered status/pointer-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ACCEPT;
      r_wr_ptr     <= '0;
      r_line_start <= '0;
      r_line_len   <= '0;
      r_line_count <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_ptr_we     <= 1'b0;
      r_ptr_line   <= '0;
      r_ptr_data   <= '0;
    end else if (tbl_clr) begin
      r_state      <= ST_ACCEPT;
      r_wr_ptr     <= '0;
      r_line_start <= '0;
      r_line_len   <= '0;
      r_line_count <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_ptr_we     <= 1'b0;
      r_ptr_line   <= '0;
      r_ptr_data   <= '0;
    end else begin
      r_ptr_we   <= 1'b0;
      r_ptr_line <= '0;
      r_ptr_data <= '0;
      case (r_state)
        ST_ACCEPT: begin
          if (w_store) begin
            r_wr_ptr   <= r_wr_ptr + WR_PTR_W'(1);
            r_line_len <= w_len_nxt;
          end
          if (w_ovf) begin
            r_err   <= 1'b1;
            r_state <= ST_HALT;
          end else if (w_commit) begin
            // Pointer entry is registered here so it appears during COMMIT.
            r_ptr_we   <= 1'b1;
            r_ptr_line <= r_line_count[FIELD_W-1:0];
            r_ptr_data <= pack_ptr(w_len_nxt, r_line_start);
            r_state    <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_line_count <= r_line_count + LINE_CNT_W'(1);
          r_line_start <= r_wr_ptr[FIELD_W-1:0];
          r_line_len   <= '0;
          r_full       <= (r_line_count + LINE_CNT_W'(1) == LINE_CNT_W'(MAX_LINES)) |
                          (r_wr_ptr == WR_PTR_W'(CHAR_DEPTH));
          r_state      <= ST_ACCEPT;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_ACCEPT;
        end
      endcase
    end
  end

  assign s_in.in_ready = w_ready;

  // Char-memory port is driven only on a storing beat, zero otherwise.
  assign mem_we     = w_store;
  assign mem_addr   = w_store ? MEM_ADDR_W'(r_wr_ptr[FIELD_W-1:0]) : '0;
  assign mem_din    = w_store ? w_pair : '0;

  assign ptr_we     = r_ptr_we;
  assign ptr_line   = r_ptr_line;
  assign ptr_data   = r_ptr_data;
  assign line_count = r_line_count;
  assign full       = r_full;
  assign err        = r_err;

endmodule

// File: tb/tb_tex_table_writer.sv
// Purpose : directed self-checking bench for tex_table_writer. Covers reset
//           state, single and multi-line writes, held-valid across COMMIT,
//           full via char-memory exhaustion, overflow/err with clear, async
//           reset mid-line and blank-pair handling (TEX_WR_BLANK_SKIP_EN).
module tb_tex_table_writer;
  import tex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_clr;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        ptr_we;
  logic [5:0]  ptr_line;
  logic [11:0] ptr_data;
  logic [6:0]  line_count;
  logic        full;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  tex_table_writer_if u_if ();

  tex_table_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tbl_clr    (tbl_clr),
    .s_in       (u_if),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .ptr_we     (ptr_we),
    .ptr_line   (ptr_line),
    .ptr_data   (ptr_data),
    .line_count (line_count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] l, input logic [7:0] r, input logic last);
    u_if.in_valid = v;
    u_if.in_lhs   = l;
    u_if.in_rhs   = r;
    u_if.in_last  = last;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_ready"},  32'(u_if.in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we),        32'd0);
    chk({tag, "_addr"},   32'(mem_addr),      32'd0);
    chk({tag, "_din"},    32'(mem_din),       32'd0);
    chk({tag, "_ptr_we"}, 32'(ptr_we),        32'd0);
    chk({tag, "_line"},   32'(ptr_line),      32'd0);
    chk({tag, "_pdata"},  32'(ptr_data),      32'd0);
    chk({tag, "_lcnt"},   32'(line_count),    32'd0);
    chk({tag, "_full"},   32'(full),          32'd0);
    chk({tag, "_err"},    32'(err),           32'd0);
  endtask

  // One accepted, stored beat: written to exp_addr in the same cycle.
  task automatic beat(input logic [7:0] l, input logic [7:0] r, input logic last, input int exp_addr);
    drive(1'b1, l, r, last);
    @(negedge clk);
    chk("beat_ready", 32'(u_if.in_ready), 32'd1);
    chk("beat_we",    32'(mem_we),        32'd1);
    chk("beat_addr",  32'(mem_addr),      32'(exp_addr));
    chk("beat_din",   32'(mem_din),       32'({l, r}));
    tick();
  endtask

  // COMMIT cycle: pointer write, ready low, no char write. Inputs left as set.
  task automatic commit_chk(input int exp_line, input logic [11:0] exp_data);
    @(negedge clk);
    chk("cmt_ptr_we", 32'(ptr_we),        32'd1);
    chk("cmt_line",   32'(ptr_line),      32'(exp_line));
    chk("cmt_data",   32'(ptr_data),      32'(exp_data));
    chk("cmt_ready",  32'(u_if.in_ready), 32'd0);
    chk("cmt_mem_we", 32'(mem_we),        32'd0);
    tick();
  endtask

  // Clear pulse with a beat offered at the same time: the beat must be refused.
  task automatic clr();
    drive(1'b1, 8'h41, 8'h42, 1'b0);
    tbl_clr = 1'b1;
    @(negedge clk);
    chk("clr_mem_we", 32'(mem_we),        32'd0);
    chk("clr_ready",  32'(u_if.in_ready), 32'd0);
    tick();
    tbl_clr = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("clr_lcnt",   32'(line_count),    32'd0);
    chk("clr_err",    32'(err),           32'd0);
    chk("clr_full",   32'(full),          32'd0);
    chk("clr_ready",  32'(u_if.in_ready), 32'd1);
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    tbl_clr = 1'b0;
    drive(1'b1, 8'h55, 8'h66, 1'b1);
    #12;
    @(negedge clk);
    zero_chk("rst");
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single 2-beat line.
    beat(8'h31, 8'h31, 1'b0, 0);
    beat(8'h73, 8'h73, 1'b1, 1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    commit_chk(0, 12'h080);
    @(negedge clk);
    chk("t1_ptr_we_off", 32'(ptr_we),        32'd0);
    chk("t1_lcnt",       32'(line_count),    32'd1);
    chk("t1_ready",      32'(u_if.in_ready), 32'd1);
    tick();

    // Two lines of 3 and 2 beats.
    clr();
    beat(8'h61, 8'h41, 1'b0, 0);
    beat(8'h62, 8'h42, 1'b0, 1);
    beat(8'h63, 8'h43, 1'b1, 2);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    commit_chk(0, 12'h0C0);
    beat(8'h64, 8'h44, 1'b0, 3);
    beat(8'h65, 8'h45, 1'b1, 4);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    commit_chk(1, 12'h083);
    @(negedge clk);
    chk("t2_lcnt", 32'(line_count), 32'd2);
    tick();

    // Valid held through the last beat: next beat waits out COMMIT.
    beat(8'h61, 8'h62, 1'b0, 5);
    beat(8'h63, 8'h64, 1'b1, 6);
    drive(1'b1, 8'h78, 8'h79, 1'b1);
    commit_chk(2, 12'h085);
    beat(8'h78, 8'h79, 1'b1, 7);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    commit_chk(3, 12'h047);
    @(negedge clk);
    chk("t3_lcnt", 32'(line_count), 32'd4);
    tick();

    // Two 32-pair lines exhaust the char memory -> full.
    clr();
    for (int i = 0; i < 64; i++) begin
      beat(8'(8'h30 + i), 8'(i), ((i == 31) || (i == 63)), i);
      if (i == 31) begin
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        commit_chk(0, 12'h800);
      end
    end
    drive(1'b1, 8'h7e, 8'h7e, 1'b0);
    commit_chk(1, 12'h820);
    @(negedge clk);
    chk("full_flag",  32'(full),          32'd1);
    chk("full_ready", 32'(u_if.in_ready), 32'd0);
    chk("full_we",    32'(mem_we),        32'd0);
    chk("full_lcnt",  32'(line_count),    32'd2);
    tick();

    // 65 beats without in_last: overflow on the beat at address 63.
    clr();
    for (int i = 0; i < 64; i++) begin
      beat(8'(i), 8'(~i), 1'b0, i);
    end
    drive(1'b1, 8'h5a, 8'h5a, 1'b0);
    @(negedge clk);
    chk("ovf_err",    32'(err),           32'd1);
    chk("ovf_ready",  32'(u_if.in_ready), 32'd0);
    chk("ovf_mem_we", 32'(mem_we),        32'd0);
    chk("ovf_ptr_we", 32'(ptr_we),        32'd0);
    chk("ovf_full",   32'(full),          32'd0);
    tick();
    @(negedge clk);
    chk("halt_ptr_we", 32'(ptr_we), 32'd0);
    chk("halt_err",    32'(err),    32'd1);
    tick();
    clr();

    // Async reset in the middle of a line.
    beat(8'h7a, 8'h7a, 1'b1, 0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    commit_chk(0, 12'h040);
    beat(8'h71, 8'h71, 1'b0, 1);
    drive(1'b1, 8'h72, 8'h72, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    zero_chk("midrst");
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("midrst_ptr_we", 32'(ptr_we), 32'd0);
    rst_n = 1'b1;
    tick();
    beat(8'h6e, 8'h6e, 1'b1, 0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    commit_chk(0, 12'h040);
    @(negedge clk);
    chk("t5_lcnt", 32'(line_count), 32'd1);
    tick();

    // Blank pair in the middle of a line.
    clr();
    beat(8'h61, 8'h61, 1'b0, 0);
`ifdef TEX_WR_BLANK_SKIP_EN
    drive(1'b1, 8'h20, 8'h20, 1'b0);
    @(negedge clk);
    chk("blank_ready", 32'(u_if.in_ready), 32'd1);
    chk("blank_we",    32'(mem_we),        32'd0);
    tick();
    beat(8'h62, 8'h62, 1'b1, 1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    commit_chk(0, 12'h080);
`else
    beat(8'h20, 8'h20, 1'b0, 1);
    beat(8'h62, 8'h62, 1'b1, 2);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    commit_chk(0, 12'h0C0);
`endif
    @(negedge clk);
    chk("t6_lcnt", 32'(line_count), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
